// File: rtl/wb_sram_responder.sv
// Wishbone slave SRAM target. Word-organised memory with byte lanes, programmable wait
// states, a fast path for sequential cab bursts, and err/rty termination of bad or busy accesses.
module wb_sram_responder #(
    parameter int            DW          = 32,
    parameter int            AW          = 32,
    parameter int            SW          = 4,
    parameter int            DEPTH       = 1024,
    parameter logic [AW-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int            WAIT_STATES = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          we_i,
    input  logic          cab_i,
    input  logic [AW-1:0] adr_i,
    input  logic [SW-1:0] sel_i,
    input  logic [DW-1:0] dat_i,
    input  logic          busy_i,
    output logic [DW-1:0] dat_o,
    output logic          ack_o,
    output logic          err_o,
    output logic          rty_o,
    output logic [1:0]    dbg_state
);

    localparam int LSB = $clog2(SW);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [AW:0] WIN_END = {1'b0, BASE_ADDR} + (AW+1)'(DEPTH * SW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        T_ACK = 2'd0,
        T_ERR = 2'd1,
        T_RTY = 2'd2
    } term_t;

    state_t        state_q, state_d;
    term_t         term_q, req_term;
    logic [3:0]    cnt_q;
    logic [IW-1:0] idx_q, req_idx;
    logic          we_q, cab_q;
    logic [SW-1:0] sel_q;
    logic [DW-1:0] dat_q;
    logic [AW-1:0] adr_q;
    logic          burst_q;
    logic [AW-1:0] last_adr_q;
    logic          last_we_q;
    logic          req, in_range, aligned, seq_hit, fast;
    logic [AW-1:0] offset;
    logic          unused_ok;
    logic [DW-1:0] mem [DEPTH];

    // Handshake: a request is cyc_i & stb_i sampled in IDLE. The master holds adr/sel/dat/we
    // until a termination; exactly one of ack/err/rty then pulses for a single cycle. Dropping
    // cyc_i or stb_i while waiting abandons the access silently.
    assign req      = cyc_i & stb_i;
    assign offset   = adr_i - BASE_ADDR;
    assign in_range = (adr_i >= BASE_ADDR) && ({1'b0, adr_i} < WIN_END);
    assign aligned  = (adr_i[LSB-1:0] == '0);
    assign req_idx  = offset[LSB +: IW];
    assign unused_ok = ^{offset[AW-1:LSB+IW], offset[LSB-1:0]};

    // A burst continuation reuses the previous acked beat's direction at the next word.
    assign seq_hit = burst_q && cab_i && (we_i == last_we_q)
                  && (adr_i == last_adr_q + AW'(SW));

    always_comb begin
        req_term = T_ACK;
        if (!in_range || !aligned) begin
            req_term = T_ERR;
        end else if (busy_i) begin
            req_term = T_RTY;
        end
    end

    assign fast = (req_term != T_ACK) || seq_hit || (WAIT_STATES == 0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = fast ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            term_q     <= T_ACK;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            cab_q      <= 1'b0;
            sel_q      <= '0;
            dat_q      <= '0;
            adr_q      <= '0;
            burst_q    <= 1'b0;
            last_adr_q <= '0;
            last_we_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        term_q <= req_term;
                        idx_q  <= req_idx;
                        we_q   <= we_i;
                        cab_q  <= cab_i;
                        sel_q  <= sel_i;
                        dat_q  <= dat_i;
                        adr_q  <= adr_i;
                        cnt_q  <= 4'(WAIT_STATES - 1);
                        if (!cab_i) begin
                            burst_q <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        burst_q <= 1'b0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (term_q == T_ACK) begin
                        burst_q    <= cab_q;
                        last_adr_q <= adr_q;
                        last_we_q  <= we_q;
                    end else begin
                        burst_q <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Losing the bus cycle always ends any burst in progress.
            if (!cyc_i) begin
                burst_q <= 1'b0;
            end
        end
    end

    // Memory is not reset; a write lands only on the edge leaving an ack cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i && state_q == S_RESP && term_q == T_ACK && we_q) begin
            for (int b = 0; b < SW; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][b*8 +: 8] <= dat_q[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        ack_o = 1'b0;
        err_o = 1'b0;
        rty_o = 1'b0;
        dat_o = '0;
        if (state_q == S_RESP) begin
            case (term_q)
                T_ACK: begin
                    ack_o = 1'b1;
                    if (!we_q) begin
                        dat_o = mem[idx_q];
                    end
                end
                T_ERR:   err_o = 1'b1;
                T_RTY:   rty_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Bench for wb_sram_responder: one instance with 1 wait state, one with 3, checked against
// a byte-level memory and burst model driven by the access rules.
module tb_wb_sram_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, cab = 1'b0, busy = 1'b0;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = '0;
    int          tgt = 0;

    logic        cyc_a, stb_a, cyc_b, stb_b;
    logic [31:0] dat_a, dat_b;
    logic        ack_a, err_a, rty_a, ack_b, err_b, rty_b;
    logic [1:0]  dbg_a, dbg_b;
    logic        obs_ack, obs_err, obs_rty;
    logic [31:0] obs_dat;

    assign cyc_a   = cyc & (tgt == 0);
    assign stb_a   = stb & (tgt == 0);
    assign cyc_b   = cyc & (tgt == 1);
    assign stb_b   = stb & (tgt == 1);
    assign obs_ack = (tgt == 0) ? ack_a : ack_b;
    assign obs_err = (tgt == 0) ? err_a : err_b;
    assign obs_rty = (tgt == 0) ? rty_a : rty_b;
    assign obs_dat = (tgt == 0) ? dat_a : dat_b;

    wb_sram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(1)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc_a), .stb_i(stb_a), .we_i(we), .cab_i(cab),
        .adr_i(adr), .sel_i(sel), .dat_i(dat), .busy_i(busy), .dat_o(dat_a),
        .ack_o(ack_a), .err_o(err_a), .rty_o(rty_a), .dbg_state(dbg_a)
    );

    wb_sram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc_b), .stb_i(stb_b), .we_i(we), .cab_i(cab),
        .adr_i(adr), .sel_i(sel), .dat_i(dat), .busy_i(busy), .dat_o(dat_b),
        .ack_o(ack_b), .err_o(err_b), .rty_o(rty_b), .dbg_state(dbg_b)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: per-instance word memory plus the "last beat was a cab ack" record.
    int          ws [2] = '{1, 3};
    logic [31:0] m_mem [2][DEPTH];
    bit          m_flag [2];
    logic [31:0] m_prev_adr [2];
    logic        m_prev_we [2];

    // kind: 0 none, 1 ack, 2 err, 3 rty. lat counts clock edges from the sampling edge.
    task automatic model_step(input int t, input logic [31:0] a, input logic w,
                              input logic [3:0] s, input logic [31:0] d, input logic c,
                              input logic b, output int ek, output int el,
                              output logic [31:0] er);
        int          idx;
        logic [31:0] word;
        m_flag[1-t] = 1'b0;
        er = '0;
        if (a < BASE || a >= BASE + DEPTH * 4 || a % 4 != 0) begin
            ek = 2; el = 1; m_flag[t] = 1'b0;
        end else if (b) begin
            ek = 3; el = 1; m_flag[t] = 1'b0;
        end else begin
            ek = 1;
            el = (c && m_flag[t] && a == m_prev_adr[t] + 4 && w == m_prev_we[t]) ? 1 : ws[t] + 1;
            idx  = int'((a - BASE) / 4);
            word = m_mem[t][idx];
            if (w) begin
                for (int i = 0; i < 4; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
                m_mem[t][idx] = word;
            end else begin
                er = word;
            end
            m_flag[t] = c; m_prev_adr[t] = a; m_prev_we[t] = w;
        end
    endtask

    // Starts just after a negedge with the target idle; returns one negedge after the DUT
    // is idle again. stray counts cycles with data outside ack, overlapping or repeated terminations.
    task automatic drive_access(input int t, input logic [31:0] a, input logic w,
                                input logic [3:0] s, input logic [31:0] d, input logic c,
                                input logic b, output int kind, output int lat,
                                output logic [31:0] rd, output int stray);
        tgt = t; adr = a; we = w; sel = s; dat = d; cab = c; busy = b;
        cyc = 1'b1; stb = 1'b1;
        kind = 0; lat = 0; rd = '0; stray = 0;
        @(posedge clk);
        #1 busy = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (obs_ack || obs_err || obs_rty) begin
                lat  = i;
                kind = obs_ack ? 1 : (obs_err ? 2 : 3);
                if (int'(obs_ack) + int'(obs_err) + int'(obs_rty) > 1) stray++;
                rd = obs_dat;
                break;
            end
            if (obs_dat !== '0) stray++;
        end
        stb = 1'b0;
        if (!c) cyc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (obs_ack || obs_err || obs_rty || obs_dat !== '0) stray++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({ack_a, err_a, rty_a, ack_b, err_b, rty_b} !== 6'b0 || dat_a !== '0 || dat_b !== '0) begin
            tests_failed++;
            $display("FAIL reset: terms=%b dat_a=%h dat_b=%h, need all 0",
                     {ack_a, err_a, rty_a, ack_b, err_b, rty_b}, dat_a, dat_b);
        end
        rst_n = 1'b1;
        m_flag[0] = 1'b0; m_flag[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_init;
        int k, l, st, ek, el;
        logic [31:0] rd, er, d;
        for (int t = 0; t < 2; t++) begin
            for (int w = 0; w < 64; w++) begin
                d = $urandom;
                model_step(t, 32'(w * 4), 1'b1, 4'hF, d, 1'b0, 1'b0, ek, el, er);
                drive_access(t, 32'(w * 4), 1'b1, 4'hF, d, 1'b0, 1'b0, k, l, rd, st);
                tests_run++;
                if (k !== ek || l !== el || st !== 0) begin
                    tests_failed++;
                    $display("FAIL init t%0d w%0d: kind=%0d lat=%0d stray=%0d, need kind=%0d lat=%0d stray=0",
                             t, w, k, l, st, ek, el);
                end
            end
        end
    endtask

    task automatic test_basic;
        int k, l, st, ek, el;
        logic [31:0] rd, er;
        logic        wv [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            model_step(0, 32'h10, wv[i], 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, ek, el, er);
            drive_access(0, 32'h10, wv[i], 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, k, l, rd, st);
            tests_run++;
            if (k !== 1 || l !== 2 || rd !== er || st !== 0) begin
                tests_failed++;
                $display("FAIL basic %0d: kind=%0d lat=%0d dat=%h stray=%0d, need kind=1 lat=2 dat=%h stray=0",
                         i, k, l, rd, st, er);
            end
        end
        tests_run++;
        if (rd !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL basic_read: dat=%h, need deadbeef", rd);
        end
    endtask

    task automatic test_byte_lanes;
        int k, l, st, ek, el;
        logic [31:0] rd, er;
        logic        wv [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0]  sv [3] = '{4'hF, 4'b0101, 4'hF};
        logic [31:0] dv [3] = '{32'h11223344, 32'hAABBCCDD, 32'h0};
        for (int i = 0; i < 3; i++) begin
            model_step(0, 32'h20, wv[i], sv[i], dv[i], 1'b0, 1'b0, ek, el, er);
            drive_access(0, 32'h20, wv[i], sv[i], dv[i], 1'b0, 1'b0, k, l, rd, st);
            tests_run++;
            if (k !== ek || l !== el || rd !== er || st !== 0) begin
                tests_failed++;
                $display("FAIL lanes %0d: kind=%0d lat=%0d dat=%h stray=%0d, need kind=%0d lat=%0d dat=%h",
                         i, k, l, rd, st, ek, el, er);
            end
        end
        tests_run++;
        if (rd !== 32'h11BB33DD) begin
            tests_failed++;
            $display("FAIL lanes_merge: dat=%h, need 11bb33dd", rd);
        end
    endtask

    task automatic test_errors;
        int k, l, st, ek, el;
        logic [31:0] rd, er;
        logic [31:0] av [5] = '{32'h1000, 32'h02, 32'h1000, 32'h12, 32'h10};
        logic        wv [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            model_step(0, av[i], wv[i], 4'hF, 32'h55555555, 1'b0, 1'b0, ek, el, er);
            drive_access(0, av[i], wv[i], 4'hF, 32'h55555555, 1'b0, 1'b0, k, l, rd, st);
            tests_run++;
            if (k !== ek || l !== el || rd !== er || st !== 0 || (i < 4 && (k !== 2 || l !== 1))) begin
                tests_failed++;
                $display("FAIL err %0d: kind=%0d lat=%0d dat=%h stray=%0d, need kind=%0d lat=%0d dat=%h",
                         i, k, l, rd, st, ek, el, er);
            end
        end
        tests_run++;
        if (rd !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL err_nowrite: dat=%h, need deadbeef", rd);
        end
    endtask

    task automatic test_retry;
        int k, l, st, ek, el;
        logic [31:0] rd, er;
        logic        wv [3] = '{1'b1, 1'b1, 1'b0};
        logic        bv [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] dv [3] = '{32'hCAFEF00D, 32'h12345678, 32'h0};
        for (int i = 0; i < 3; i++) begin
            model_step(0, 32'h30, wv[i], 4'hF, dv[i], 1'b0, bv[i], ek, el, er);
            drive_access(0, 32'h30, wv[i], 4'hF, dv[i], 1'b0, bv[i], k, l, rd, st);
            tests_run++;
            if (k !== ek || l !== el || rd !== er || st !== 0 || (i == 1 && (k !== 3 || l !== 1))) begin
                tests_failed++;
                $display("FAIL rty %0d: kind=%0d lat=%0d dat=%h stray=%0d, need kind=%0d lat=%0d dat=%h",
                         i, k, l, rd, st, ek, el, er);
            end
        end
        tests_run++;
        if (rd !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL rty_nowrite: dat=%h, need cafef00d", rd);
        end
    endtask

    task automatic test_burst;
        int k, l, st, ek, el;
        logic [31:0] rd, er;
        logic [31:0] av [4] = '{32'h40, 32'h44, 32'h48, 32'h50};
        int          lv [4] = '{4, 1, 1, 4};
        for (int i = 0; i < 4; i++) begin
            model_step(1, av[i], 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, ek, el, er);
            drive_access(1, av[i], 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, k, l, rd, st);
            tests_run++;
            if (k !== 1 || l !== lv[i] || l !== el || rd !== er || st !== 0) begin
                tests_failed++;
                $display("FAIL burst %0d: kind=%0d lat=%0d dat=%h stray=%0d, need kind=1 lat=%0d dat=%h",
                         i, k, l, rd, st, lv[i], er);
            end
        end
        cyc = 1'b0; cab = 1'b0;
        m_flag[0] = 1'b0; m_flag[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort;
        int k, l, st, ek, el, seen;
        logic [31:0] rd, er;
        tgt = 1; adr = 32'h60; we = 1'b1; sel = 4'hF; dat = 32'h0BAD0BAD; cab = 1'b0;
        busy = 1'b0; cyc = 1'b1; stb = 1'b1;
        seen = 0;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (obs_ack || obs_err || obs_rty) seen++;
            if (i == 2) begin stb = 1'b0; cyc = 1'b0; end
        end
        m_flag[0] = 1'b0; m_flag[1] = 1'b0;
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL abort_term: %0d termination cycles, need 0", seen);
        end
        model_step(1, 32'h60, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, ek, el, er);
        drive_access(1, 32'h60, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, k, l, rd, st);
        tests_run++;
        if (k !== ek || l !== el || rd !== er || st !== 0) begin
            tests_failed++;
            $display("FAIL abort_nowrite: kind=%0d lat=%0d dat=%h, need kind=%0d lat=%0d dat=%h",
                     k, l, rd, ek, el, er);
        end
    endtask

    task automatic test_reset_mid;
        int k, l, st, ek, el;
        logic [31:0] rd, er;
        tgt = 1; adr = 32'h64; we = 1'b1; sel = 4'hF; dat = 32'hFEEDFACE; cab = 1'b0;
        busy = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({ack_b, err_b, rty_b} !== 3'b0 || dat_b !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: terms=%b dat=%h, need 0", {ack_b, err_b, rty_b}, dat_b);
        end
        cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
        m_flag[0] = 1'b0; m_flag[1] = 1'b0;
        @(negedge clk);
        model_step(1, 32'h64, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, ek, el, er);
        drive_access(1, 32'h64, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, k, l, rd, st);
        tests_run++;
        if (k !== ek || l !== el || rd !== er || st !== 0) begin
            tests_failed++;
            $display("FAIL reset_nowrite: kind=%0d lat=%0d dat=%h, need kind=%0d lat=%0d dat=%h",
                     k, l, rd, ek, el, er);
        end
    endtask

    task automatic test_random;
        int k, l, st, ek, el, t, r;
        logic [31:0] rd, er, a, d;
        logic        w, c, b;
        logic [3:0]  s;
        for (int n = 0; n < 80; n++) begin
            t = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
            else if (r == 1) a = 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
            else             a = 32'(4 * $urandom_range(0, 63));
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            c = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0 && m_flag[t] && m_prev_adr[t] < 32'hF8) begin
                a = m_prev_adr[t] + 32'd4; w = m_prev_we[t]; c = 1'b1; b = 1'b0;
            end
            model_step(t, a, w, s, d, c, b, ek, el, er);
            drive_access(t, a, w, s, d, c, b, k, l, rd, st);
            tests_run++;
            if (k !== ek || l !== el || rd !== er || st !== 0) begin
                tests_failed++;
                $display("FAIL random %0d t%0d a=%h we=%b: kind=%0d lat=%0d dat=%h stray=%0d, need kind=%0d lat=%0d dat=%h",
                         n, t, a, w, k, l, rd, st, ek, el, er);
            end
        end
        cyc = 1'b0; cab = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_init;
        test_basic;
        test_byte_lanes;
        test_errors;
        test_retry;
        test_burst;
        test_abort;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
